// File: rtl/segment_scan_controller_if.sv
// Bus bundle for segment_scan_controller: scan control, digit-buffer write port
// and the two 74HC595 chain drive groups.
//   scan_en             run scanning (0 = finish current digit, then idle)
//   wr_en/wr_digit/wr_segments  one-cycle write strobe into the digit buffer
//   com_* / seg_*       ser, srclk, rclk, active-low oe for each 595 chain
//   frame_done          pulse on the final latch cycle of digit 7
//   busy                high whenever the scanner is not idle
// master = stimulus side, slave = the controller.
interface segment_scan_controller_if;
    logic       scan_en;
    logic       wr_en;
    logic [2:0] wr_digit;
    logic [7:0] wr_segments;
    logic       com_ser;
    logic       com_srclk;
    logic       com_rclk;
    logic       com_oe;
    logic       seg_ser;
    logic       seg_srclk;
    logic       seg_rclk;
    logic       seg_oe;
    logic       frame_done;
    logic       busy;

    modport master (
        output scan_en, wr_en, wr_digit, wr_segments,
        input  com_ser, com_srclk, com_rclk, com_oe,
        input  seg_ser, seg_srclk, seg_rclk, seg_oe,
        input  frame_done, busy
    );

    modport slave (
        input  scan_en, wr_en, wr_digit, wr_segments,
        output com_ser, com_srclk, com_rclk, com_oe,
        output seg_ser, seg_srclk, seg_rclk, seg_oe,
        output frame_done, busy
    );
endinterface

// File: rtl/segment_scan_controller.sv
// Multiplexed 8-digit seven-segment scanner driving two daisy-free 74HC595
// chains (digit selector + segments) in lockstep, MSB first.
// Ports:
//   clock     system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       segment_scan_controller_if.slave (scan control, buffer write,
//             com_/seg_ ser/srclk/rclk/oe, frame_done, busy)
// Parameters: SHIFT_DIV (srclk half period), HOLD_CYCLES (display-on time per
// digit), BLANK_CYCLES (ghost-suppression blank, blanking build only).
// Build option: define SEGMENT_SCAN_BLANKING_EN to blank the outputs from LOAD
// through LATCH plus BLANK_CYCLES at the start of HOLD.
// All outputs are registered from next-state values so they line up with the
// state the FSM is in during that cycle.
module segment_scan_controller #(
    parameter int unsigned SHIFT_DIV    = 4,
    parameter int unsigned HOLD_CYCLES  = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    segment_scan_controller_if.slave  bus
);

    localparam int unsigned DIV_W      = 8;
    localparam int unsigned HOLD_W     = 16;
    localparam int unsigned SR_W       = 8;
    localparam int unsigned DIGIT_W    = 3;
    localparam int unsigned BIT_W      = 3;
    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SHIFT_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(7);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(7);

    // Reject out-of-range configurations at elaboration.
    if (SHIFT_DIV == 0 || SHIFT_DIV > 255 ||
        HOLD_CYCLES == 0 || HOLD_CYCLES > 65535 ||
        BLANK_CYCLES == 0 || BLANK_CYCLES > 255) begin : g_param_check
        $error("segment_scan_controller: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_HOLD
    } state_e;

    state_e                             state_q, state_d;
    logic [DIV_W-1:0]                   div_cnt_q, div_cnt_d;
    logic [HOLD_W-1:0]                  hold_cnt_q, hold_cnt_d;
    logic [BIT_W-1:0]                   bit_cnt_q, bit_cnt_d;
    logic [DIGIT_W-1:0]                 digit_q, digit_d;
    logic [SR_W-1:0]                    seg_sr_q, seg_sr_d;
    logic [SR_W-1:0]                    com_sr_q, com_sr_d;
    logic                               latched_q, latched_d;
    logic [NUM_DIGITS-1:0][SR_W-1:0]    digit_buf_q, digit_buf_d;

    logic com_ser_q, com_ser_d;
    logic seg_ser_q, seg_ser_d;
    logic srclk_q, srclk_d;
    logic rclk_q, rclk_d;
    logic oe_q, oe_d;
    logic frame_done_q, frame_done_d;
    logic busy_q, busy_d;

    logic [SR_W-1:0] load_seg;
    logic            shifting;
    logic            blank;

    // Digit buffer write port; writes land on the same edge at any time.
    always_comb begin
        digit_buf_d = digit_buf_q;
        if (bus.wr_en) begin
            digit_buf_d[bus.wr_digit] = bus.wr_segments;
        end
    end

    // Bypass so a write to the digit being loaded in the LOAD cycle is captured.
    always_comb begin
        load_seg = digit_buf_q[digit_q];
        if (bus.wr_en && (bus.wr_digit == digit_q)) begin
            load_seg = bus.wr_segments;
        end
    end

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        hold_cnt_d = hold_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        digit_d    = digit_q;
        seg_sr_d   = seg_sr_q;
        com_sr_d   = com_sr_q;
        latched_d  = latched_q;

        unique case (state_q)
            S_IDLE: begin
                // A new scan must latch fresh data before the outputs enable.
                latched_d = 1'b0;
                if (bus.scan_en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                seg_sr_d  = load_seg;
                com_sr_d  = SR_W'(1) << digit_q;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                state_d   = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    state_d   = S_SHIFT_HI;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_SHIFT_HI: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    seg_sr_d  = {seg_sr_q[SR_W-2:0], 1'b0};
                    com_sr_d  = {com_sr_q[SR_W-2:0], 1'b0};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_LATCH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        state_d   = S_SHIFT_LO;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_LATCH: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d  = '0;
                    hold_cnt_d = '0;
                    latched_d  = 1'b1;
                    state_d    = S_HOLD;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    digit_d    = digit_q + DIGIT_W'(1);
                    state_d    = bus.scan_en ? S_LOAD : S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        shifting = (state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI);

`ifdef SEGMENT_SCAN_BLANKING_EN
        blank = (state_d == S_LOAD) || shifting || (state_d == S_LATCH) ||
                ((state_d == S_HOLD) && (hold_cnt_d < HOLD_W'(BLANK_CYCLES)));
`else
        blank = 1'b0;
`endif

        com_ser_d    = shifting ? com_sr_d[SR_W-1] : 1'b0;
        seg_ser_d    = shifting ? seg_sr_d[SR_W-1] : 1'b0;
        srclk_d      = (state_d == S_SHIFT_HI);
        rclk_d       = (state_d == S_LATCH);
        oe_d         = (state_d == S_IDLE) || blank || !latched_d;
        frame_done_d = (state_d == S_LATCH) && (div_cnt_d == DIV_LAST) &&
                       (digit_d == DIGIT_LAST);
        busy_d       = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            digit_q      <= '0;
            seg_sr_q     <= '0;
            com_sr_q     <= '0;
            latched_q    <= 1'b0;
            digit_buf_q  <= '0;
            com_ser_q    <= 1'b0;
            seg_ser_q    <= 1'b0;
            srclk_q      <= 1'b0;
            rclk_q       <= 1'b0;
            oe_q         <= 1'b1;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            digit_q      <= digit_d;
            seg_sr_q     <= seg_sr_d;
            com_sr_q     <= com_sr_d;
            latched_q    <= latched_d;
            digit_buf_q  <= digit_buf_d;
            com_ser_q    <= com_ser_d;
            seg_ser_q    <= seg_ser_d;
            srclk_q      <= srclk_d;
            rclk_q       <= rclk_d;
            oe_q         <= oe_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // Both chains share one clock/latch/enable timing.
    assign bus.com_ser    = com_ser_q;
    assign bus.seg_ser    = seg_ser_q;
    assign bus.com_srclk  = srclk_q;
    assign bus.seg_srclk  = srclk_q;
    assign bus.com_rclk   = rclk_q;
    assign bus.seg_rclk   = rclk_q;
    assign bus.com_oe     = oe_q;
    assign bus.seg_oe     = oe_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_segment_scan_controller.sv
// Directed bench for segment_scan_controller (SHIFT_DIV=2, HOLD_CYCLES=10,
// BLANK_CYCLES=3). Each scanned digit's expected {com, seg} bytes are queued
// when a scan is started; a negedge monitor assembles the bits seen on srclk
// rising edges and compares at each latch pulse.
module tb_segment_scan_controller;

    localparam int unsigned SD     = 2;
    localparam int unsigned HC     = 10;
    localparam int unsigned BC     = 3;
    localparam int unsigned PERIOD = 1 + 17 * SD + HC;

`ifdef SEGMENT_SCAN_BLANKING_EN
    localparam logic BLANK_ON = 1'b1;
`else
    localparam logic BLANK_ON = 1'b0;
`endif

    logic clock;
    logic reset_n;

    segment_scan_controller_if bus_if ();

    segment_scan_controller #(
        .SHIFT_DIV    (SD),
        .HOLD_CYCLES  (HC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] exp_q[$];
    int          lat_times[$];
    int          fd_times[$];
    logic [7:0]  model[8];
    logic [7:0]  pat[8];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic write_digit(input int d, input logic [7:0] v);
        bus_if.wr_en       = 1'b1;
        bus_if.wr_digit    = 3'(d);
        bus_if.wr_segments = v;
        tick();
        bus_if.wr_en = 1'b0;
        model[d]     = v;
    endtask

    task automatic push_exp(input int d, input logic [7:0] seg);
        logic [7:0] c;
        c = 8'd1 << d;
        exp_q.push_back({c, seg});
    endtask

    // Raise scan_en; returns the edge number on which the DUT enters LOAD.
    task automatic start_scan(output int e0);
        bus_if.scan_en = 1'b1;
        e0 = cyc + 1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_com_ser"},   32'(bus_if.com_ser),    32'd0);
        check({tag, "_seg_ser"},   32'(bus_if.seg_ser),    32'd0);
        check({tag, "_com_srclk"}, 32'(bus_if.com_srclk),  32'd0);
        check({tag, "_seg_srclk"}, 32'(bus_if.seg_srclk),  32'd0);
        check({tag, "_com_rclk"},  32'(bus_if.com_rclk),   32'd0);
        check({tag, "_seg_rclk"},  32'(bus_if.seg_rclk),   32'd0);
        check({tag, "_com_oe"},    32'(bus_if.com_oe),     32'd1);
        check({tag, "_seg_oe"},    32'(bus_if.seg_oe),     32'd1);
        check({tag, "_frame_done"},32'(bus_if.frame_done), 32'd0);
        check({tag, "_busy"},      32'(bus_if.busy),       32'd0);
    endtask

    // Monitor: bit capture on srclk rise, scoreboard compare on rclk rise.
    initial begin
        int          nbits;
        int          rw;
        logic [7:0]  seg_acc;
        logic [7:0]  com_acc;
        logic        p_srclk;
        logic        p_rclk;
        logic [15:0] e;
        nbits = 0; rw = 0; seg_acc = '0; com_acc = '0; p_srclk = 1'b0; p_rclk = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                nbits = 0; rw = 0; p_srclk = 1'b0; p_rclk = 1'b0;
            end else begin
                check("lockstep_srclk", 32'(bus_if.com_srclk), 32'(bus_if.seg_srclk));
                check("lockstep_rclk",  32'(bus_if.com_rclk),  32'(bus_if.seg_rclk));
                if (bus_if.seg_srclk && !p_srclk) begin
                    seg_acc = {seg_acc[6:0], bus_if.seg_ser};
                    com_acc = {com_acc[6:0], bus_if.com_ser};
                    nbits++;
                end
                if (bus_if.seg_rclk && !p_rclk) begin
                    lat_times.push_back(cyc);
                    check("latch_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("bits_per_digit", 32'(nbits), 32'd8);
                        check("com_byte", 32'(com_acc), 32'(e[15:8]));
                        check("seg_byte", 32'(seg_acc), 32'(e[7:0]));
                    end
                    nbits = 0;
                end
                if (bus_if.seg_rclk) begin
                    rw++;
                end else if (p_rclk) begin
                    check("rclk_width", 32'(rw), 32'(SD));
                    rw = 0;
                end
                if (bus_if.frame_done) fd_times.push_back(cyc);
                p_srclk = bus_if.seg_srclk;
                p_rclk  = bus_if.seg_rclk;
            end
        end
    end

    initial begin
        int e0;
        pat[0] = 8'h3F; pat[1] = 8'h06; pat[2] = 8'h5B; pat[3] = 8'h4F;
        pat[4] = 8'h66; pat[5] = 8'h6D; pat[6] = 8'h7D; pat[7] = 8'h07;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        reset_n            = 1'b0;
        bus_if.scan_en     = 1'b0;
        bus_if.wr_en       = 1'b0;
        bus_if.wr_digit    = 3'd0;
        bus_if.wr_segments = 8'h00;

        // Reset state.
        repeat (3) tick();
        check_quiet("reset");
        reset_n = 1'b1;
        tick();
        check("idle_busy", 32'(bus_if.busy), 32'd0);

        // Continuous scan: two full frames plus the wrap back to digit 0.
        for (int i = 0; i < 8; i++) write_digit(i, pat[i]);
        start_scan(e0);
        for (int k = 0; k < 17; k++) push_exp(k % 8, model[k % 8]);
        goto_cyc(e0);
        check("load_busy", 32'(bus_if.busy), 32'd1);
        goto_cyc(e0 + 10);
        check("oe_first_digit_shift", 32'(bus_if.com_oe), 32'd1);
        goto_cyc(e0 + PERIOD + 10);
        check("oe_shift_after_latch", 32'(bus_if.seg_oe), 32'(BLANK_ON));
        goto_cyc(e0 + PERIOD + 35);
        check("oe_hold_c0", 32'(bus_if.com_oe), 32'(BLANK_ON));
        goto_cyc(e0 + PERIOD + 37);
        check("oe_hold_c2", 32'(bus_if.seg_oe), 32'(BLANK_ON));
        goto_cyc(e0 + PERIOD + 38);
        check("oe_hold_c3", 32'(bus_if.com_oe), 32'd0);
        goto_cyc(e0 + PERIOD + 44);
        check("oe_hold_c9", 32'(bus_if.seg_oe), 32'd0);
        goto_cyc(e0 + 16 * PERIOD + 20);
        bus_if.scan_en = 1'b0;
        goto_cyc(e0 + 17 * PERIOD + 2);
        check("run_idle_busy", 32'(bus_if.busy), 32'd0);
        check("run_idle_oe", 32'(bus_if.com_oe), 32'd1);
        check("latch_count", 32'(lat_times.size()), 32'd17);
        if (lat_times.size() == 17) begin
            check("first_latch_cycle", 32'(lat_times[0]), 32'(e0 + 33));
            for (int i = 1; i < 17; i++)
                check("digit_period", 32'(lat_times[i] - lat_times[i-1]), 32'(PERIOD));
        end
        check("frame_done_count", 32'(fd_times.size()), 32'd2);
        if (fd_times.size() == 2) begin
            check("frame_done_cycle", 32'(fd_times[0]), 32'(e0 + 7 * PERIOD + 34));
            check("frame_period", 32'(fd_times[1] - fd_times[0]), 32'(8 * PERIOD));
        end
        lat_times.delete();
        fd_times.delete();

        // scan_en dropped during the bit-3 shift: digit 1 still completes.
        start_scan(e0);
        push_exp(1, model[1]);
        goto_cyc(e0 + 13);
        check("bit3_lo_srclk", 32'(bus_if.seg_srclk), 32'd0);
        bus_if.scan_en = 1'b0;
        goto_cyc(e0 + 44);
        check("drop_hold_busy", 32'(bus_if.busy), 32'd1);
        check("drop_hold_oe", 32'(bus_if.com_oe), 32'd0);
        goto_cyc(e0 + PERIOD);
        check("drop_idle_busy", 32'(bus_if.busy), 32'd0);
        check("drop_idle_oe", 32'(bus_if.seg_oe), 32'd1);

        // Write in the LOAD cycle of digit 2 is captured.
        start_scan(e0);
        push_exp(2, 8'hA5);
        tick();
        write_digit(2, 8'hA5);
        bus_if.scan_en = 1'b0;
        goto_cyc(e0 + PERIOD + 1);
        check("wr_load_done", 32'(bus_if.busy), 32'd0);

        // Write one cycle after LOAD of digit 3 is not captured.
        start_scan(e0);
        push_exp(3, model[3]);
        tick();
        tick();
        write_digit(3, 8'h5A);
        bus_if.scan_en = 1'b0;
        goto_cyc(e0 + PERIOD + 1);
        check("wr_late_done", 32'(bus_if.busy), 32'd0);

        // Asynchronous reset in SHIFT_HI of digit 4.
        start_scan(e0);
        goto_cyc(e0 + 3);
        check("in_shift_hi", 32'(bus_if.com_srclk), 32'd1);
        reset_n = 1'b0;
        #1;
        check_quiet("async_reset");
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        bus_if.scan_en = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        start_scan(e0);
        push_exp(0, model[0]);
        tick();
        bus_if.scan_en = 1'b0;
        goto_cyc(e0 + PERIOD + 1);
        check("post_reset_done", 32'(bus_if.busy), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/segment_scan_controller.md
SEGMENT_SCAN_CONTROLLER -- requirements
Module: segment_scan_controller

Interface
REQ-001 SHALL provide parameter SHIFT_DIV, default 4: clock cycles per shift-clock half period; legal range 1..255.
REQ-002 SHALL provide parameter HOLD_CYCLES, default 1000: display-on cycles per digit; legal range 1..65535.
REQ-003 SHALL provide parameter BLANK_CYCLES, default 16: ghost-suppression blank length; legal range 1..255.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  system clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 scan_en  in  1  1 = run scanning; 0 = finish current digit, then idle.
REQ-008 wr_en  in  1  one-cycle write strobe into the digit buffer.
REQ-009 wr_digit  in  3  digit index written.
REQ-010 wr_segments  in  8  segment pattern, bit7 = DP, bit0 = segment a; 1 = lit.
REQ-011 com_ser, com_srclk, com_rclk, com_oe  out  1 each  digit-selector 595 chain: data, shift clock, latch, active-low output enable.
REQ-012 seg_ser, seg_srclk, seg_rclk, seg_oe  out  1 each  segment 595 chain; same meanings.
REQ-013 frame_done  out  1  one-cycle pulse when the digit-7 latch completes.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL hold an 8 x 8-bit digit buffer; wr_en writes wr_segments to entry wr_digit on the same edge, at any time.
REQ-016 FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, HOLD.
REQ-017 IDLE->LOAD when scan_en=1.
REQ-018 LOAD (1 cycle): capture buffer[digit] into the seg shift register; capture one-hot (1 << digit) into the com shift register.
REQ-019 A write to the digit being loaded in the LOAD cycle SHALL be captured; writes after LOAD affect the next scan of that digit.
REQ-020 SHIFT_LO: srclk=0, ser=MSB of each shift register; lasts SHIFT_DIV cycles; -> SHIFT_HI.
REQ-021 SHIFT_HI: srclk=1, ser held; lasts SHIFT_DIV cycles; on exit shift registers shift left by one and the bit counter increments.
REQ-022 SHIFT_HI exit SHALL go to SHIFT_LO after bits 0..6 and to LATCH after bit 7; 8 bits per digit, MSB first.
REQ-023 Both chains SHALL be shifted in lockstep; com_srclk == seg_srclk and com_rclk == seg_rclk on every cycle.
REQ-024 LATCH: rclk=1 and srclk=0 for SHIFT_DIV cycles; -> HOLD.
REQ-025 HOLD: oe=0 for HOLD_CYCLES cycles, then digit increments modulo 8 (7 wraps to 0).
REQ-026 HOLD exit SHALL go to LOAD if scan_en=1, else to IDLE.
REQ-027 Digit period SHALL be exactly 1 + 17*SHIFT_DIV + HOLD_CYCLES cycles.
REQ-028 frame_done SHALL pulse on the final LATCH cycle when digit == 7.
REQ-029 oe SHALL be 1 in IDLE; outside IDLE and blanking, oe SHALL be 0 once the first latch has completed.
REQ-030 scan_en deassertion mid-digit SHALL NOT abort shifting; the digit completes through HOLD.
REQ-031 Counters SHALL be sized for the parameter maxima and SHALL never wrap inside a state.

Reset
REQ-032 On reset_n=0, asynchronously: state IDLE; digit 0; all counters 0; all ser/srclk/rclk 0; com_oe = seg_oe = 1; frame_done = busy = 0; buffer entries 0x00.
REQ-033 Reset asserted mid-shift SHALL force the outputs above immediately; after release, scanning restarts at digit 0.

Configuration
REQ-034 Macro SEGMENT_SCAN_BLANKING_EN defined: oe = 1 from LOAD entry through the LATCH exit, plus BLANK_CYCLES further cycles taken from the start of HOLD; HOLD length is unchanged.
REQ-035 Macro SEGMENT_SCAN_BLANKING_EN undefined: oe is governed by REQ-029 only, and BLANK_CYCLES is ignored.

Verification (SHIFT_DIV=2, HOLD_CYCLES=10, BLANK_CYCLES=3)
REQ-036 Write 0x3F to digit 0, then scan_en=1 -> seg_ser bits 0,0,1,1,1,1,1,1 and com_ser bits 0,0,0,0,0,0,0,1 are sampled on the srclk rising edges; a 2-cycle rclk pulse follows.
REQ-037 scan_en held at 1 for 8 digits -> digit period of 45 cycles; frame_done pulses once per 360 cycles; the com pattern walks 0x01..0x80 and then wraps to 0x01.
REQ-038 scan_en dropped during the bit-3 shift -> the digit completes through HOLD; then IDLE with oe=1 and busy=0.
REQ-039 wr_en to the current digit in the LOAD cycle -> the new value is shifted; a write one cycle later -> the old value is shifted.
REQ-040 reset_n pulsed low during SHIFT_HI -> all ser/srclk/rclk drop to 0 and oe goes to 1 in the same cycle; after release the next scan is digit 0 with buffer 0x00.
REQ-041 With SEGMENT_SCAN_BLANKING_EN defined -> oe is high from LOAD through the first 3 HOLD cycles, then low for 7 cycles; with it undefined -> oe is low for all 10 HOLD cycles.
